mw_pipe_elastic: RTL and testbench

- Parametrised MEM→WB pipeline stage register for the RISC_TOY core; successor to the fixed, always-advancing MW latch.
- Adds valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, bubble suppression of the register-file write and a saturating stall counter.
- Sits between the memory stage (M2) and writeback (W), feeding the regfile write port and the WB mux.

---
 rtl/rtoy_pkg.sv | 19 +
 rtl/mw_pipe_elastic_skid_buf.sv | 111 +++++++++++
 rtl/mw_pipe_elastic.sv | 72 +++++++
 tb/tb_mw_pipe_elastic.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rtoy_pkg.sv
// Shared RISC_TOY definitions: writeback-select encodings, regfile write-off level,
// skid buffer state encoding and a payload width helper.
package rtoy_pkg;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic       WEN_OFF = 1'b1;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_FULL  = 2'd1,
    SB_SKID  = 2'd2
  } skid_state_e;

  // Width of the concatenated MEM->WB payload: {sel, wen, alu, load, pc4, wa}.
  function automatic int mw_payload_w(input int sel_w, input int data_w, input int wa_w);
    return sel_w + 1 + 3 * data_w + wa_w;
  endfunction
endpackage

// File: rtl/mw_pipe_elastic_skid_buf.sv
// Generic valid/ready stage buffer: 2-entry skid (registered in_ready) when SKID=1,
// otherwise a single register with combinational in_ready.
module skid_buf
  import rtoy_pkg::*;
#(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  generate
    if (SKID) begin : g_skid
      skid_state_e  state_q, state_d;
      logic [W-1:0] main_q, main_d;
      logic [W-1:0] skid_q, skid_d;
      logic         rdy_q, rdy_d;
      logic         push, pop;

      always_comb begin
        push    = in_valid & rdy_q;
        pop     = (state_q != SB_EMPTY) & out_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
          SB_EMPTY: if (push) begin
            state_d = SB_FULL;
            main_d  = in_data;
          end
          SB_FULL: begin
            if (push && pop) begin
              main_d = in_data;
            end else if (push) begin
              state_d = SB_SKID;
              skid_d  = in_data;
            end else if (pop) begin
              state_d = SB_EMPTY;
            end
          end
          SB_SKID: if (pop) begin
            state_d = SB_FULL;
            main_d  = skid_q;
          end
          default: state_d = SB_EMPTY;
        endcase
        // Flush wins over any same-cycle push; payload regs may keep stale data.
        if (flush) state_d = SB_EMPTY;
        rdy_d = (state_d != SB_SKID);
      end

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          state_q <= SB_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          rdy_q   <= 1'b1;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          rdy_q   <= rdy_d;
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state_q != SB_EMPTY);
      assign out_data  = main_q;
    end else begin : g_single
      logic         v_q, v_d;
      logic [W-1:0] data_q, data_d;
      logic         push;

      always_comb begin
        push   = in_valid & (~v_q | out_ready);
        v_d    = v_q;
        data_d = data_q;
        if (push) begin
          v_d    = 1'b1;
          data_d = in_data;
        end else if (v_q && out_ready) begin
          v_d = 1'b0;
        end
        if (flush) v_d = 1'b0;
      end

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          v_q    <= 1'b0;
          data_q <= '0;
        end else begin
          v_q    <= v_d;
          data_q <= data_d;
        end
      end

      assign in_ready  = ~v_q | out_ready;
      assign out_valid = v_q;
      assign out_data  = data_q;
    end
  endgenerate

endmodule

// File: rtl/mw_pipe_elastic.sv
// MEM->WB elastic stage: wraps skid_buf with regfile write masking on bubbles,
// synchronous flush and a saturating stall counter.
module mw_pipe_elastic
  import rtoy_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WADDR_W = 5,
  parameter int SEL_W   = 2,
  parameter bit SKID    = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               FLUSH,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   SelWB_M2,
  input  logic               WEN_M2,
  input  logic [DATA_W-1:0]  ALUOUT_M2,
  input  logic [DATA_W-1:0]  LoadData_M,
  input  logic [DATA_W-1:0]  PCADD4_M2,
  input  logic [WADDR_W-1:0] WA_M2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   SelWB_W,
  output logic               WEN_W,
  output logic [DATA_W-1:0]  ALUOUT_W,
  output logic [DATA_W-1:0]  LoadData_W,
  output logic [DATA_W-1:0]  PCADD4_W,
  output logic [WADDR_W-1:0] WA_W,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PAY_W = mw_payload_w(SEL_W, DATA_W, WADDR_W);

  logic [PAY_W-1:0] pay_in, pay_out;
  logic             wen_cap;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign pay_in = {SelWB_M2, WEN_M2, ALUOUT_M2, LoadData_M, PCADD4_M2, WA_M2};

  skid_buf #(.W(PAY_W), .SKID(SKID)) u_buf (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .flush     (FLUSH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {SelWB_W, wen_cap, ALUOUT_W, LoadData_W, PCADD4_W, WA_W} = pay_out;

  // A bubble must never write the regfile, regardless of the stale captured enable.
  assign WEN_W = out_valid ? wen_cap : WEN_OFF;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mw_pipe_elastic.sv
// Directed bench for mw_pipe_elastic: SKID=1 instance for the main scenarios and a
// SKID=0 instance for the combinational-ready variant; both use a 4-bit stall counter.
module tb_mw_pipe_elastic;
  import rtoy_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        FLUSH, in_valid, out_ready, WEN_M2;
  logic [1:0]  SelWB_M2;
  logic [31:0] ALUOUT_M2, LoadData_M, PCADD4_M2;
  logic [4:0]  WA_M2;

  logic        in_ready, out_valid, WEN_W;
  logic [1:0]  SelWB_W;
  logic [31:0] ALUOUT_W, LoadData_W, PCADD4_W;
  logic [4:0]  WA_W;
  logic [3:0]  stall_cnt;

  logic        n_in_ready, n_out_valid, n_WEN_W;
  logic [1:0]  n_SelWB_W;
  logic [31:0] n_ALUOUT_W, n_LoadData_W, n_PCADD4_W;
  logic [4:0]  n_WA_W;
  logic [3:0]  n_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mw_pipe_elastic #(.DATA_W(32), .WADDR_W(5), .SEL_W(2), .SKID(1'b1), .CNT_W(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(in_ready),
    .SelWB_M2(SelWB_M2), .WEN_M2(WEN_M2), .ALUOUT_M2(ALUOUT_M2), .LoadData_M(LoadData_M),
    .PCADD4_M2(PCADD4_M2), .WA_M2(WA_M2), .out_valid(out_valid), .out_ready(out_ready),
    .SelWB_W(SelWB_W), .WEN_W(WEN_W), .ALUOUT_W(ALUOUT_W), .LoadData_W(LoadData_W),
    .PCADD4_W(PCADD4_W), .WA_W(WA_W), .stall_cnt(stall_cnt)
  );

  mw_pipe_elastic #(.DATA_W(32), .WADDR_W(5), .SEL_W(2), .SKID(1'b0), .CNT_W(4)) dut_ns (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(n_in_ready),
    .SelWB_M2(SelWB_M2), .WEN_M2(WEN_M2), .ALUOUT_M2(ALUOUT_M2), .LoadData_M(LoadData_M),
    .PCADD4_M2(PCADD4_M2), .WA_M2(WA_M2), .out_valid(n_out_valid), .out_ready(out_ready),
    .SelWB_W(n_SelWB_W), .WEN_W(n_WEN_W), .ALUOUT_W(n_ALUOUT_W), .LoadData_W(n_LoadData_W),
    .PCADD4_W(n_PCADD4_W), .WA_W(n_WA_W), .stall_cnt(n_stall_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] wa, input logic wen);
    in_valid   = v;
    ALUOUT_M2  = alu;
    LoadData_M = alu + 32'h100;
    PCADD4_M2  = alu + 32'h4;
    WA_M2      = wa;
    WEN_M2     = wen;
    SelWB_M2   = WB_LOAD;
  endtask

  task automatic do_reset();
    RSTN = 1'b0; FLUSH = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (WEN_W !== 1'b1) begin bad++; $display("FAIL reset_wen got=%b exp=1", WEN_W); end
      total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if ({SelWB_W, ALUOUT_W, LoadData_W, PCADD4_W, WA_W} !== '0) begin bad++; $display("FAIL reset_payload alu=%h wa=%0d sel=%0d exp=0", ALUOUT_W, WA_W, SelWB_W); end
      tick();
    end
  endtask

  task automatic test_stream();
    logic [31:0] alu_exp [3];
    alu_exp = '{32'h10, 32'h20, 32'h30};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, alu_exp[i], 5'(i + 1), 1'b0);
      tick();
      total++; if (out_valid !== 1'b1 || ALUOUT_W !== alu_exp[i] || WA_W !== 5'(i + 1)) begin bad++; $display("FAIL stream_%0d v=%b alu=%h wa=%0d exp alu=%h wa=%0d", i, out_valid, ALUOUT_W, WA_W, alu_exp[i], i + 1); end
      total++; if (LoadData_W !== alu_exp[i] + 32'h100 || PCADD4_W !== alu_exp[i] + 32'h4 || SelWB_W !== WB_LOAD || WEN_W !== 1'b0) begin bad++; $display("FAIL stream_fields_%0d ld=%h pc=%h sel=%0d wen=%b", i, LoadData_W, PCADD4_W, SelWB_W, WEN_W); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready_%0d got=%b exp=1", i, in_ready); end
    end
    drive(1'b0, 32'h0, 5'd0, 1'b1);
    tick();
    total++; if (out_valid !== 1'b0 || WEN_W !== 1'b1) begin bad++; $display("FAIL stream_drain v=%b wen=%b exp v=0 wen=1", out_valid, WEN_W); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd10, 1'b0);
    tick();
    total++; if (out_valid !== 1'b1 || ALUOUT_W !== 32'hA || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin bad++; $display("FAIL bp_first v=%b alu=%h rdy=%b cnt=%0d exp 1/a/1/0", out_valid, ALUOUT_W, in_ready, stall_cnt); end
    drive(1'b1, 32'hB, 5'd11, 1'b0);
    tick();
    total++; if (ALUOUT_W !== 32'hA || in_ready !== 1'b0 || stall_cnt !== 4'd1) begin bad++; $display("FAIL bp_skid alu=%h rdy=%b cnt=%0d exp a/0/1", ALUOUT_W, in_ready, stall_cnt); end
    drive(1'b0, 32'h0, 5'd0, 1'b1);
    tick();
    total++; if (ALUOUT_W !== 32'hA || WA_W !== 5'd10 || in_ready !== 1'b0 || stall_cnt !== 4'd2) begin bad++; $display("FAIL bp_hold alu=%h wa=%0d rdy=%b cnt=%0d exp a/10/0/2", ALUOUT_W, WA_W, in_ready, stall_cnt); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || ALUOUT_W !== 32'hB || WA_W !== 5'd11 || in_ready !== 1'b1 || stall_cnt !== 4'd2) begin bad++; $display("FAIL bp_second v=%b alu=%h wa=%0d rdy=%b cnt=%0d exp 1/b/11/1/2", out_valid, ALUOUT_W, WA_W, in_ready, stall_cnt); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || WEN_W !== 1'b1) begin bad++; $display("FAIL bp_empty v=%b rdy=%b wen=%b exp 0/1/1", out_valid, in_ready, WEN_W); end
  endtask

  task automatic test_flush();
    // Fill to SKID, then flush with a push of 0xC presented.
    out_ready = 1'b0;
    drive(1'b1, 32'hD, 5'd13, 1'b0);
    tick();
    drive(1'b1, 32'hE, 5'd14, 1'b0);
    tick();
    total++; if (in_ready !== 1'b0 || stall_cnt !== 4'd3) begin bad++; $display("FAIL flush_pre rdy=%b cnt=%0d exp 0/3", in_ready, stall_cnt); end
    FLUSH = 1'b1;
    drive(1'b1, 32'hC, 5'd12, 1'b0);
    tick();
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    total++; if (out_valid !== 1'b0 || WEN_W !== 1'b1 || in_ready !== 1'b1 || stall_cnt !== 4'd4) begin bad++; $display("FAIL flush_skid v=%b wen=%b rdy=%b cnt=%0d exp 0/1/1/4", out_valid, WEN_W, in_ready, stall_cnt); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || stall_cnt !== 4'd4) begin bad++; $display("FAIL flush_skid_after v=%b cnt=%0d exp 0/4", out_valid, stall_cnt); end
    // Flush from FULL with an accepted push: the pushed entry is dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'h7, 5'd7, 1'b0);
    tick();
    FLUSH = 1'b1;
    drive(1'b1, 32'hC, 5'd12, 1'b0);
    tick();
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    total++; if (out_valid !== 1'b0 || WEN_W !== 1'b1 || stall_cnt !== 4'd5) begin bad++; $display("FAIL flush_full v=%b wen=%b cnt=%0d exp 0/1/5", out_valid, WEN_W, stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b0 || stall_cnt !== 4'd5) begin bad++; $display("FAIL flush_dropped_%0d v=%b alu=%h cnt=%0d exp v=0 cnt=5", i, out_valid, ALUOUT_W, stall_cnt); end
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(1'b1, 32'h11, 5'd17, 1'b0);
    tick();
    total++; if (out_valid !== 1'b1 || WEN_W !== 1'b0) begin bad++; $display("FAIL bubble_entry v=%b wen=%b exp 1/0", out_valid, WEN_W); end
    drive(1'b0, 32'h11, 5'd17, 1'b0);
    tick();
    total++; if (out_valid !== 1'b0 || WEN_W !== 1'b1) begin bad++; $display("FAIL bubble_masked v=%b wen=%b exp 0/1", out_valid, WEN_W); end
  endtask

  task automatic test_noskid();
    do_reset();
    total++; if (n_in_ready !== 1'b1 || n_out_valid !== 1'b0 || n_WEN_W !== 1'b1) begin bad++; $display("FAIL ns_reset rdy=%b v=%b wen=%b exp 1/0/1", n_in_ready, n_out_valid, n_WEN_W); end
    drive(1'b1, 32'h44, 5'd4, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    total++; if (n_out_valid !== 1'b1 || n_ALUOUT_W !== 32'h44 || n_in_ready !== 1'b0) begin bad++; $display("FAIL ns_full v=%b alu=%h rdy=%b exp 1/44/0", n_out_valid, n_ALUOUT_W, n_in_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (n_in_ready !== 1'b1) begin bad++; $display("FAIL ns_comb_ready got=%b exp=1", n_in_ready); end
    drive(1'b1, 32'h55, 5'd5, 1'b0);
    tick();
    total++; if (n_out_valid !== 1'b1 || n_ALUOUT_W !== 32'h55 || n_WA_W !== 5'd5) begin bad++; $display("FAIL ns_replace v=%b alu=%h wa=%0d exp 1/55/5", n_out_valid, n_ALUOUT_W, n_WA_W); end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    total++; if (n_out_valid !== 1'b0 || n_WEN_W !== 1'b1) begin bad++; $display("FAIL ns_drain v=%b wen=%b exp 0/1", n_out_valid, n_WEN_W); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h33, 5'd3, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        total++; if (stall_cnt !== 4'd14) begin bad++; $display("FAIL sat_mid got=%0d exp=14", stall_cnt); end
      end
    end
    total++; if (stall_cnt !== 4'd15 || out_valid !== 1'b1 || ALUOUT_W !== 32'h33) begin bad++; $display("FAIL sat_top cnt=%0d v=%b alu=%h exp 15/1/33", stall_cnt, out_valid, ALUOUT_W); end
    RSTN = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || WEN_W !== 1'b1 || stall_cnt !== 4'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ctl v=%b wen=%b cnt=%0d rdy=%b exp 0/1/0/1", out_valid, WEN_W, stall_cnt, in_ready); end
    total++; if ({SelWB_W, ALUOUT_W, LoadData_W, PCADD4_W, WA_W} !== '0 || n_stall_cnt !== 4'd0) begin bad++; $display("FAIL async_rst_data alu=%h wa=%0d ns_cnt=%0d exp 0", ALUOUT_W, WA_W, n_stall_cnt); end
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
  endtask

  initial begin
    RSTN = 1'b0; FLUSH = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b1);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_noskid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
